// File: rtl/spi_master_frame_collector.sv
// SPI MOSI frame collector: synchronises CSN/SCLK/MOSI into clk, splits each frame into
// cmd/addr/dummy/data fields of per-frame length and presents the result on a valid/ready port.
module spi_master_frame_collector #(
    parameter int CMD_W       = 32,
    parameter int ADDR_W      = 32,
    parameter int DUMMY_W     = 16,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 6,
    parameter bit SAMPLE_FALL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_csn,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic [LEN_W-1:0]  cfg_cmd_len,
    input  logic [LEN_W-1:0]  cfg_addr_len,
    input  logic [LEN_W-1:0]  cfg_dummy_len,
    input  logic [LEN_W-1:0]  cfg_data_len,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [CMD_W-1:0]  pkt_cmd,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic [DATA_W-1:0] pkt_data,
    output logic [2:0]        pkt_flag,
    output logic [15:0]       pkt_bits,
    output logic              pkt_trunc,
    output logic              pkt_overrun,
    output logic              drop_sticky,
    input  logic              drop_clr
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_OVR} state_t;

    localparam logic [LEN_W-1:0] CMD_MAX   = LEN_W'(CMD_W);
    localparam logic [LEN_W-1:0] ADDR_MAX  = LEN_W'(ADDR_W);
    localparam logic [LEN_W-1:0] DUMMY_MAX = LEN_W'(DUMMY_W);
    localparam logic [LEN_W-1:0] DATA_MAX  = LEN_W'(DATA_W);

    function automatic logic [LEN_W-1:0] clamp(input logic [LEN_W-1:0] len,
                                               input logic [LEN_W-1:0] mx);
        return (len > mx) ? mx : len;
    endfunction

    // First field with a nonzero length, in frame order; OVR when none remain.
    function automatic state_t first_state(input logic [LEN_W-1:0] c, input logic [LEN_W-1:0] a,
                                           input logic [LEN_W-1:0] d, input logic [LEN_W-1:0] t);
        if (c != '0) return S_CMD;
        if (a != '0) return S_ADDR;
        if (d != '0) return S_DUMMY;
        if (t != '0) return S_DATA;
        return S_OVR;
    endfunction

    logic r_csn_s1, r_csn_s2, r_csn_h;
    logic r_sclk_s1, r_sclk_s2, r_sclk_h;
    logic r_mosi_s1, r_mosi_s2, r_mosi_h;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {r_csn_s1, r_csn_s2, r_csn_h}    <= 3'b111;
            {r_sclk_s1, r_sclk_s2, r_sclk_h} <= 3'b000;
            {r_mosi_s1, r_mosi_s2, r_mosi_h} <= 3'b000;
        end else begin
            {r_csn_s1, r_csn_s2, r_csn_h}    <= {spi_csn, r_csn_s1, r_csn_s2};
            {r_sclk_s1, r_sclk_s2, r_sclk_h} <= {spi_sclk, r_sclk_s1, r_sclk_s2};
            {r_mosi_s1, r_mosi_s2, r_mosi_h} <= {spi_mosi, r_mosi_s1, r_mosi_s2};
        end
    end

    logic w_csn_fall, w_csn_rise, w_sclk_edge, w_bit;
    assign w_csn_fall  = r_csn_h & ~r_csn_s2;
    assign w_csn_rise  = ~r_csn_h & r_csn_s2;
    assign w_sclk_edge = SAMPLE_FALL ? (r_sclk_h & ~r_sclk_s2) : (~r_sclk_h & r_sclk_s2);
    // MOSI as seen alongside the pre-edge SCLK sample, i.e. the set-up value.
    assign w_bit       = r_mosi_h;

    logic [LEN_W-1:0] w_cmd_cl, w_addr_cl, w_dummy_cl, w_data_cl;
    assign w_cmd_cl   = clamp(cfg_cmd_len, CMD_MAX);
    assign w_addr_cl  = clamp(cfg_addr_len, ADDR_MAX);
    assign w_dummy_cl = clamp(cfg_dummy_len, DUMMY_MAX);
    assign w_data_cl  = clamp(cfg_data_len, DATA_MAX);

    state_t            r_state, w_state_nxt;
    logic [LEN_W-1:0]  r_len_cmd, r_len_addr, r_len_dummy, r_len_data, r_cnt, w_cur_len;
    logic              w_field_done, w_in_field;
    logic [CMD_W-1:0]  r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [2:0]        r_seen;
    logic [15:0]       r_bits;
    logic              r_ovr, r_trunc, r_fin;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_cur_len = '0;
        case (r_state)
            S_CMD:   w_cur_len = r_len_cmd;
            S_ADDR:  w_cur_len = r_len_addr;
            S_DUMMY: w_cur_len = r_len_dummy;
            S_DATA:  w_cur_len = r_len_data;
            default: w_cur_len = '0;
        endcase
        w_in_field   = (r_state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA});
        w_field_done = w_in_field && ((r_cnt + LEN_W'(1)) == w_cur_len);
        w_state_nxt  = r_state;
        if (r_state == S_IDLE) begin
            if (w_csn_fall) w_state_nxt = first_state(w_cmd_cl, w_addr_cl, w_dummy_cl, w_data_cl);
        end else if (w_csn_rise) begin
            w_state_nxt = S_IDLE;
        end else if (w_sclk_edge && w_field_done) begin
            case (r_state)
                S_CMD:   w_state_nxt = first_state('0, r_len_addr, r_len_dummy, r_len_data);
                S_ADDR:  w_state_nxt = first_state('0, '0, r_len_dummy, r_len_data);
                S_DUMMY: w_state_nxt = first_state('0, '0, '0, r_len_data);
                default: w_state_nxt = S_OVR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {r_len_cmd, r_len_addr, r_len_dummy, r_len_data, r_cnt} <= '0;
            r_cmd   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_seen  <= '0;
            r_bits  <= '0;
            r_ovr   <= 1'b0;
            r_trunc <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_csn_fall) begin
                    r_len_cmd   <= w_cmd_cl;
                    r_len_addr  <= w_addr_cl;
                    r_len_dummy <= w_dummy_cl;
                    r_len_data  <= w_data_cl;
                    r_cnt       <= '0;
                    r_cmd       <= '0;
                    r_addr      <= '0;
                    r_data      <= '0;
                    r_seen      <= '0;
                    r_bits      <= '0;
                    r_ovr       <= 1'b0;
                    r_trunc     <= 1'b0;
                end
            end else if (w_csn_rise) begin
                r_fin   <= 1'b1;
                r_trunc <= w_in_field;
            end else if (w_sclk_edge) begin
                if (r_bits != 16'hFFFF) r_bits <= r_bits + 16'd1;
                r_cnt <= w_field_done ? '0 : r_cnt + LEN_W'(1);
                case (r_state)
                    S_CMD:   begin r_cmd  <= (r_cmd << 1) | CMD_W'(w_bit);   r_seen[0] <= 1'b1; end
                    S_ADDR:  begin r_addr <= (r_addr << 1) | ADDR_W'(w_bit); r_seen[1] <= 1'b1; end
                    S_DATA:  begin r_data <= (r_data << 1) | DATA_W'(w_bit); r_seen[2] <= 1'b1; end
                    S_OVR:   r_ovr <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Output register: a finished frame loads unless a held packet is still waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_valid   <= 1'b0;
            pkt_cmd     <= '0;
            pkt_addr    <= '0;
            pkt_data    <= '0;
            pkt_flag    <= '0;
            pkt_bits    <= '0;
            pkt_trunc   <= 1'b0;
            pkt_overrun <= 1'b0;
            drop_sticky <= 1'b0;
        end else begin
            if (r_fin && !(pkt_valid && !pkt_ready)) begin
                pkt_valid   <= 1'b1;
                pkt_cmd     <= r_cmd;
                pkt_addr    <= r_addr;
                pkt_data    <= r_data;
                pkt_flag    <= r_seen;
                pkt_bits    <= r_bits;
                pkt_trunc   <= r_trunc;
                pkt_overrun <= r_ovr;
            end else if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end
            drop_sticky <= (drop_sticky & ~drop_clr) | (r_fin & pkt_valid & ~pkt_ready);
        end
    end

endmodule

// File: tb/tb_spi_master_frame_collector.sv
// Scoreboard bench: bit-banged SPI frames, a positional reference model and two DUTs
// (rising- and falling-edge sampling) checked by independent packet monitors.
module tb_spi_master_frame_collector;

    localparam int CW = 32, AW = 32, DW = 16, TW = 32, LW = 6;

    typedef struct {
        logic [31:0] cmd, addr, data;
        logic [2:0]  flag;
        logic [15:0] bits;
        logic        trunc, ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic csn = 1'b1, sclk = 1'b0, mosi_r = 1'b0, mosi_f = 1'b0;
    logic [LW-1:0] cfg_c = '0, cfg_a = '0, cfg_d = '0, cfg_t = '0;
    logic ready_r = 1'b1, ready_f = 1'b1, clr_r = 1'b0, clr_f = 1'b0;

    logic        v_r, v_f, tr_r, tr_f, ov_r, ov_f, ds_r, ds_f;
    logic [31:0] c_r, c_f, a_r, a_f, d_r, d_f;
    logic [2:0]  f_r, f_f;
    logic [15:0] b_r, b_f;

    int n_chk = 0, n_fail = 0;
    exp_t q_r[$], q_f[$];
    logic [255:0] cur_bv;
    int cur_n;

    always #5 clk = ~clk;

    spi_master_frame_collector #(.CMD_W(CW), .ADDR_W(AW), .DUMMY_W(DW), .DATA_W(TW),
                                 .LEN_W(LW), .SAMPLE_FALL(1'b0)) u_rise (
        .clk(clk), .rst_n(rst_n), .spi_csn(csn), .spi_sclk(sclk), .spi_mosi(mosi_r),
        .cfg_cmd_len(cfg_c), .cfg_addr_len(cfg_a), .cfg_dummy_len(cfg_d), .cfg_data_len(cfg_t),
        .pkt_valid(v_r), .pkt_ready(ready_r), .pkt_cmd(c_r), .pkt_addr(a_r), .pkt_data(d_r),
        .pkt_flag(f_r), .pkt_bits(b_r), .pkt_trunc(tr_r), .pkt_overrun(ov_r),
        .drop_sticky(ds_r), .drop_clr(clr_r));

    spi_master_frame_collector #(.CMD_W(CW), .ADDR_W(AW), .DUMMY_W(DW), .DATA_W(TW),
                                 .LEN_W(LW), .SAMPLE_FALL(1'b1)) u_fall (
        .clk(clk), .rst_n(rst_n), .spi_csn(csn), .spi_sclk(sclk), .spi_mosi(mosi_f),
        .cfg_cmd_len(cfg_c), .cfg_addr_len(cfg_a), .cfg_dummy_len(cfg_d), .cfg_data_len(cfg_t),
        .pkt_valid(v_f), .pkt_ready(ready_f), .pkt_cmd(c_f), .pkt_addr(a_f), .pkt_data(d_f),
        .pkt_flag(f_f), .pkt_bits(b_f), .pkt_trunc(tr_f), .pkt_overrun(ov_f),
        .drop_sticky(ds_f), .drop_clr(clr_f));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_pkt(input string tag, input exp_t e, input logic [31:0] c,
                             input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                             input logic [15:0] b, input logic t, input logic o);
        chk({tag, ".cmd"},   64'(c), 64'(e.cmd));
        chk({tag, ".addr"},  64'(a), 64'(e.addr));
        chk({tag, ".data"},  64'(d), 64'(e.data));
        chk({tag, ".flag"},  64'(f), 64'(e.flag));
        chk({tag, ".bits"},  64'(b), 64'(e.bits));
        chk({tag, ".trunc"}, 64'(t), 64'(e.trunc));
        chk({tag, ".ovr"},   64'(o), 64'(e.ovr));
    endtask

    // Monitors: a packet is consumed at any edge where valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && v_r && ready_r) begin
            if (q_r.size() == 0) chk("rise.unexpected_pkt", 64'(c_r), 64'hDEAD_0000_0000);
            else check_pkt("rise", q_r.pop_front(), c_r, a_r, d_r, f_r, b_r, tr_r, ov_r);
        end
    end

    always @(negedge clk) begin
        if (rst_n && v_f && ready_f) begin
            if (q_f.size() == 0) chk("fall.unexpected_pkt", 64'(c_f), 64'hDEAD_0000_0000);
            else check_pkt("fall", q_f.pop_front(), c_f, a_f, d_f, f_f, b_f, tr_f, ov_f);
        end
    end

    // Reference: bit i of the frame belongs to whichever field its position falls in.
    function automatic exp_t model(input int c, input int a, input int d, input int t, input int n);
        exp_t e;
        int tot;
        e = '{cmd: 0, addr: 0, data: 0, flag: 0, bits: 0, trunc: 0, ovr: 0};
        c = (c > CW) ? CW : c;
        a = (a > AW) ? AW : a;
        d = (d > DW) ? DW : d;
        t = (t > TW) ? TW : t;
        for (int i = 0; i < n; i++) begin
            if (i < c) begin
                e.cmd = {e.cmd[30:0], cur_bv[i]}; e.flag[0] = 1'b1;
            end else if (i < c + a) begin
                e.addr = {e.addr[30:0], cur_bv[i]}; e.flag[1] = 1'b1;
            end else if (i >= c + a + d && i < c + a + d + t) begin
                e.data = {e.data[30:0], cur_bv[i]}; e.flag[2] = 1'b1;
            end
        end
        tot = c + a + d + t;
        e.bits = 16'(n);
        e.trunc = (n < tot);
        e.ovr = (n > tot);
        return e;
    endfunction

    function automatic void put(input logic [31:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            cur_bv[cur_n] = v[i];
            cur_n++;
        end
    endfunction

    function automatic void rand_bits(input int n);
        for (int k = 0; k < 8; k++) cur_bv[k*32 +: 32] = $urandom;
        cur_n = n;
    endfunction

    task automatic clks(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            mosi_r = cur_bv[i];
            clks(6);
            sclk = 1'b1;
            clks(3);
            mosi_f = cur_bv[i];
            clks(3);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int c, input int a, input int d, input int t,
                             input bit drop_r, output exp_t e);
        cfg_c = LW'(c); cfg_a = LW'(a); cfg_d = LW'(d); cfg_t = LW'(t);
        clks(2);
        csn = 1'b0;
        clks(6);
        cfg_c = LW'($urandom); cfg_a = LW'($urandom);
        cfg_d = LW'($urandom); cfg_t = LW'($urandom);
        send_bits(cur_n);
        clks(6);
        csn = 1'b1;
        e = model(c, a, d, t, cur_n);
        if (!drop_r) q_r.push_back(e);
        q_f.push_back(e);
        clks(10);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e, e_held;
        int lc, la, ld, lt;

        clks(5);
        chk("reset.valid", 64'(v_r), 64'd0);
        chk("reset.drop",  64'(ds_r), 64'd0);
        chk("reset.bits",  64'(b_r), 64'd0);
        chk("reset.flag",  64'(f_r), 64'd0);
        chk("reset.cmd",   64'(c_r), 64'd0);
        rst_n = 1'b1;
        clks(3);

        // T1 directed
        cur_bv = '0; cur_n = 0;
        put(32'h0B, 8); put(32'h123456, 24); put(32'hDEADBEEF, 32);
        run_frame(8, 24, 0, 32, 1'b0, e);
        // T2 dummy bits discarded
        cur_bv = '0; cur_n = 0;
        put(32'h9F, 8); put(32'h5A, 8); put(32'hA5C3, 16);
        run_frame(8, 0, 8, 16, 1'b0, e);
        // T3 truncated in address
        cur_bv = '0; cur_n = 0;
        put(32'h03, 8); put(32'hABC, 12);
        run_frame(8, 24, 0, 32, 1'b0, e);
        // T4 overrun
        cur_bv = '0; cur_n = 0;
        put(32'h3C, 8); put(32'hE7, 8); put(32'hF, 4);
        run_frame(8, 0, 0, 8, 1'b0, e);
        // Length clamping, all-zero lengths, zero-edge frame with nonzero lengths
        rand_bits(44);
        run_frame(40, 8, 0, 4, 1'b0, e);
        rand_bits(5);
        run_frame(0, 0, 0, 0, 1'b0, e);
        rand_bits(0);
        run_frame(0, 0, 0, 0, 1'b0, e);
        rand_bits(0);
        run_frame(4, 0, 0, 4, 1'b0, e);

        for (int f = 0; f < 12; f++) begin
            lc = $urandom_range(0, 40); la = $urandom_range(0, 40);
            ld = $urandom_range(0, 20); lt = $urandom_range(0, 40);
            rand_bits($urandom_range(0, 100));
            run_frame(lc, la, ld, lt, 1'b0, e);
        end

        // T5 back-pressure and drop
        chk("drop.before", 64'(ds_r), 64'd0);
        ready_r = 1'b0;
        rand_bits(24);
        run_frame(8, 8, 0, 8, 1'b0, e_held);
        rand_bits(16);
        run_frame(8, 0, 0, 8, 1'b1, e);
        chk("drop.sticky", 64'(ds_r), 64'd1);
        chk("drop.held_valid", 64'(v_r), 64'd1);
        check_pkt("held", e_held, c_r, a_r, d_r, f_r, b_r, tr_r, ov_r);
        ready_r = 1'b1;
        clks(3);
        chk("drop.valid_after_hs", 64'(v_r), 64'd0);
        chk("drop.sticky_kept", 64'(ds_r), 64'd1);
        clr_r = 1'b1;
        clks(1);
        clr_r = 1'b0;
        clks(1);
        chk("drop.cleared", 64'(ds_r), 64'd0);

        // T6 reset in the middle of a frame
        rand_bits(10);
        cfg_c = 8; cfg_a = 24; cfg_d = 0; cfg_t = 32;
        clks(2);
        csn = 1'b0;
        clks(6);
        send_bits(10);
        rst_n = 1'b0;
        csn = 1'b1;
        clks(1);
        rst_n = 1'b1;
        clks(12);
        chk("rstmid.rise_valid", 64'(v_r), 64'd0);
        chk("rstmid.fall_valid", 64'(v_f), 64'd0);
        cur_bv = '0; cur_n = 0;
        put(32'h0B, 8); put(32'h123456, 24); put(32'hDEADBEEF, 32);
        run_frame(8, 24, 0, 32, 1'b0, e);

        clks(20);
        chk("rise.queue_empty", 64'(q_r.size()), 64'd0);
        chk("fall.queue_empty", 64'(q_f.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
